laplace_window_gen: RTL

Streaming 3x3 cross-window generator that feeds the Laplace kernel stage. It accepts raster-order 8-bit grayscale pixels and buffers the two previous image rows. For every interior pixel it outputs the five taps the kernel consumes: b (up), d (left), e (centre), f (right) and h (down). Border pixels produce no window, so the kernel stage only ever sees fully populated windows.

---
 rtl/laplace_window_gen.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/laplace_window_gen.sv
// ----------------------------------------------------------------------------
// laplace_window_gen
//
// Streaming 3x3 cross-window generator for the Laplace kernel stage.
// Raster-order 8-bit pixels go in. Two line buffers hold the previous two
// rows. For every interior pixel the five cross taps come out, one clock
// after the pixel that completes the window has been accepted.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input pixel valid (no backpressure)
//   in_sof     start of frame, qualified by in_valid, marks pixel (0,0)
//   in_pix     8-bit input pixel
//   out_valid  single-cycle pulse per emitted window
//   out_b      tap (y-1, x)
//   out_d      tap (y, x-1)
//   out_e      tap (y, x), the centre
//   out_f      tap (y, x+1)
//   out_h      tap (y+1, x)
//   out_x      centre column
//   out_y      centre row
//   out_eof    high with out_valid on the last window of the frame
// ----------------------------------------------------------------------------
module laplace_window_gen #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [7:0]         in_pix,
    output logic               out_valid,
    output logic [7:0]         out_b,
    output logic [7:0]         out_d,
    output logic [7:0]         out_e,
    output logic [7:0]         out_f,
    output logic [7:0]         out_h,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_eof
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);
    localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t state;

    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;

    // lb1 holds row r-1, lb2 holds row r-2, both indexed by column
    logic [7:0] lb1 [IMG_W];
    logic [7:0] lb2 [IMG_W];

    // Column history: top row (r-2), middle row (r-1, two deep), bottom row (r)
    logic [7:0] top_d1;
    logic [7:0] mid_d1;
    logic [7:0] mid_d2;
    logic [7:0] bot_d1;

    logic               start;
    logic               accept;
    logic [COORD_W-1:0] cur_c;
    logic [COORD_W-1:0] cur_r;
    logic [AW-1:0]      idx;
    logic [7:0]         top_rd;
    logic [7:0]         mid_rd;
    logic               at_last_col;
    logic               at_last_row;

    // A sof pixel always restarts the frame at (0,0), both from IDLE and
    // mid-frame; otherwise the running counters give the pixel position.
    assign start       = in_valid && in_sof;
    assign accept      = in_valid && ((state == S_ACTIVE) || in_sof);
    assign cur_c       = start ? '0 : col;
    assign cur_r       = start ? '0 : row;
    assign idx         = cur_c[AW-1:0];
    assign top_rd      = lb2[idx];
    assign mid_rd      = lb1[idx];
    assign at_last_col = (cur_c == LAST_COL);
    assign at_last_row = (cur_r == LAST_ROW);

    // Line buffers: the new pixel goes into lb1 and the row it displaces
    // slides down into lb2. Contents are never reset because no window is
    // emitted before both rows have been rewritten by the current frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[idx] <= in_pix;
            lb2[idx] <= mid_rd;
        end
    end

    // Frame FSM, position counters, column history and registered outputs.
    // The c>=2 gate guarantees the column history was refilled by the
    // current row, so no taps from the previous row can leak into a window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            col       <= '0;
            row       <= '0;
            top_d1    <= '0;
            mid_d1    <= '0;
            mid_d2    <= '0;
            bot_d1    <= '0;
            out_valid <= 1'b0;
            out_b     <= '0;
            out_d     <= '0;
            out_e     <= '0;
            out_f     <= '0;
            out_h     <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_eof   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            if (accept) begin
                top_d1 <= top_rd;
                mid_d2 <= mid_d1;
                mid_d1 <= mid_rd;
                bot_d1 <= in_pix;

                if (at_last_col) begin
                    col <= '0;
                    if (at_last_row) begin
                        row   <= '0;
                        state <= S_IDLE;
                    end else begin
                        row   <= cur_r + ONE;
                        state <= S_ACTIVE;
                    end
                end else begin
                    col   <= cur_c + ONE;
                    row   <= cur_r;
                    state <= S_ACTIVE;
                end

                if ((cur_r >= TWO) && (cur_c >= TWO)) begin
                    out_valid <= 1'b1;
                    out_b     <= top_d1;
                    out_d     <= mid_d2;
                    out_e     <= mid_d1;
                    out_f     <= mid_rd;
                    out_h     <= bot_d1;
                    out_x     <= cur_c - ONE;
                    out_y     <= cur_r - ONE;
                    out_eof   <= at_last_col && at_last_row;
                end
            end
        end
    end

endmodule
